vram_write_arbiter: RTL and testbench

Shares the single video-memory write port of the VGA controller (pixel address, 3-bit colour, write enable) between up to NUM_REQ pixel producers, e.g. CPU store path, line drawer and sprite blitter. It runs on the 48 MHz system clock. It turns per-requester req/ack handshakes into correctly spaced write pulses: one cycle with the write enable high, then at least one cycle low, because the controller edge-detects the enable for its read-modify-write. It also rejects out-of-range addresses. Optionally it contains a hardware screen-clear engine.

---
 rtl/vram_write_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_vram_write_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the single VGA VRAM write port: registered write pulses, each followed by a low cycle.
// Optional hardware screen-clear engine, built when VRAM_CLEAR_ENGINE_EN is defined.
module vram_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 3,
    parameter int PIXELS  = 19200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Handshake: a requester holds req with stable addr/data until it sees its one-cycle ack,
    // which marks the write slot; it may drop req or present a new write in that same cycle.
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [ADDR_W-1:0]         vram_addr,
    output logic [DATA_W-1:0]         vram_data,
    output logic                      vram_we,
    output logic                      busy,
    output logic                      oob_error,
    input  logic                      clear_start,
    input  logic [DATA_W-1:0]         clear_color,
    output logic                      clear_busy,
    output logic [2:0]                dbg_state_o
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W+1)'(PIXELS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        GAP       = 3'd2,
        CLEAR_WR  = 3'd3,
        CLEAR_GAP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_q, we_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                oob_q, oob_d;
    logic                arb;

    // Round-robin search starting just after the last winner.
    logic                found;
    logic [GW-1:0]       win;
    logic [GW-1:0]       cand;
    int                  idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                win_oob;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int j = 1; j <= NUM_REQ; j++) begin
            idx = int'(last_q) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = GW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_addr = req_addr[win*ADDR_W +: ADDR_W];
    assign win_data = req_data[win*DATA_W +: DATA_W];
    assign win_oob  = ({1'b0, win_addr} >= PIX_LIMIT);

`ifdef VRAM_CLEAR_ENGINE_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    logic                clr_pend_q, clr_pend_d;
    logic                clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   clr_color_q, clr_color_d;
`else
    logic                unused_clear;
    assign unused_clear = ^{clear_start, clear_color};
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        ack_d   = '0;
        oob_d   = 1'b0;
        arb     = 1'b0;
`ifdef VRAM_CLEAR_ENGINE_EN
        clr_pend_d  = clr_pend_q;
        clr_busy_d  = clr_busy_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        if (clear_start && !clr_busy_q) begin
            clr_pend_d  = 1'b1;
            clr_busy_d  = 1'b1;
            clr_color_d = clear_color;
        end
`endif
        case (state_q)
            IDLE, GAP: arb = 1'b1;
            WRITE:     state_d = GAP;
`ifdef VRAM_CLEAR_ENGINE_EN
            CLEAR_WR:  state_d = CLEAR_GAP;
            CLEAR_GAP: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    arb        = 1'b1;
                    clr_busy_d = 1'b0;
                end else begin
                    state_d   = CLEAR_WR;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    addr_d    = clr_cnt_q + 1'b1;
                    we_d      = 1'b1;
                end
            end
`endif
            default:   state_d = IDLE;
        endcase

        // A pending clear outranks every requester at an arbitration point.
        if (arb) begin
            state_d = IDLE;
`ifdef VRAM_CLEAR_ENGINE_EN
            if (clr_pend_d) begin
                state_d    = CLEAR_WR;
                clr_pend_d = 1'b0;
                clr_cnt_d  = '0;
                addr_d     = '0;
                data_d     = clr_color_d;
                we_d       = 1'b1;
            end else
`endif
            if (found) begin
                state_d    = WRITE;
                last_d     = win;
                addr_d     = win_addr;
                data_d     = win_data;
                ack_d[win] = 1'b1;
                we_d       = !win_oob;
                oob_d      = win_oob;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= GW'(NUM_REQ - 1);
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            oob_q   <= oob_d;
        end
    end

`ifdef VRAM_CLEAR_ENGINE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pend_q  <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
        end else begin
            clr_pend_q  <= clr_pend_d;
            clr_busy_q  <= clr_busy_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
        end
    end
    assign clear_busy = clr_busy_q;
`else
    assign clear_busy = 1'b0;
`endif

    assign vram_addr   = addr_q;
    assign vram_data   = data_q;
    assign vram_we     = we_q;
    assign ack         = ack_q;
    assign oob_error   = oob_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_vram_write_arbiter.sv
`timescale 1ns/1ps
// Bench for vram_write_arbiter: directed scenarios plus a randomized run checked against
// a slot-timing reference model (one write slot, then at least one idle cycle).
module tb_vram_write_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 3;
    localparam int PIXELS  = 19200;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        ack;
    logic [ADDR_W-1:0]         vram_addr;
    logic [DATA_W-1:0]         vram_data;
    logic                      vram_we;
    logic                      busy;
    logic                      oob_error;
    logic                      clear_start = 1'b0;
    logic [DATA_W-1:0]         clear_color = '0;
    logic                      clear_busy;
    logic [2:0]                dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    vram_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIXELS(PIXELS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
        .busy(busy), .oob_error(oob_error), .clear_start(clear_start),
        .clear_color(clear_color), .clear_busy(clear_busy), .dbg_state_o(dbg_state)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        clear_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        set_slot(0, 15'd1, 3'd1);
        set_slot(1, 15'd2, 3'd2);
        set_slot(2, 15'd3, 3'd3);
        req = 3'b111;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", vram_we); end
        n_cmp++; if (vram_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", vram_addr); end
        n_cmp++; if (vram_data !== '0) begin n_err++; $display("FAIL reset_data: got %0d want 0", vram_data); end
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL reset_ack: got %b want 000", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (oob_error !== 1'b0) begin n_err++; $display("FAIL reset_oob: got %b want 0", oob_error); end
        n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL reset_clear_busy: got %b want 0", clear_busy); end
        req = '0;
        rst_n = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        set_slot(1, 15'd100, 3'd5);
        req = 3'b010;
        step();
        req = 3'b000;
        n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL single_we: got %b want 1", vram_we); end
        n_cmp++; if (vram_addr !== 15'd100) begin n_err++; $display("FAIL single_addr: got %0d want 100", vram_addr); end
        n_cmp++; if (vram_data !== 3'd5) begin n_err++; $display("FAIL single_data: got %0d want 5", vram_data); end
        n_cmp++; if (ack !== 3'b010) begin n_err++; $display("FAIL single_ack: got %b want 010", ack); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        step();
        n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL single_gap_we: got %b want 0", vram_we); end
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL single_gap_ack: got %b want 000", ack); end
        n_cmp++; if (vram_addr !== 15'd100) begin n_err++; $display("FAIL single_gap_addr: got %0d want 100", vram_addr); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int   grants[NUM_REQ];
        logic prev_we;
        logic [NUM_REQ-1:0] e_ack;
        int   k;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            grants[i] = 0;
            set_slot(i, ADDR_W'((i + 1) * 10), DATA_W'(i + 1));
        end
        prev_we = 1'b0;
        req = 3'b111;
        for (int c = 0; c < 12; c++) begin
            step();
            k = (c / 2) % NUM_REQ;
            e_ack = (c % 2 == 0) ? (3'b001 << k) : 3'b000;
            n_cmp++; if (ack !== e_ack) begin n_err++; $display("FAIL rr_ack c=%0d: got %b want %b", c, ack, e_ack); end
            n_cmp++; if (vram_we !== (c % 2 == 0)) begin n_err++; $display("FAIL rr_we c=%0d: got %b want %b", c, vram_we, (c % 2 == 0)); end
            n_cmp++; if (vram_addr !== ADDR_W'((k + 1) * 10)) begin n_err++; $display("FAIL rr_addr c=%0d: got %0d want %0d", c, vram_addr, (k + 1) * 10); end
            n_cmp++; if (prev_we && vram_we) begin n_err++; $display("FAIL rr_spacing c=%0d: got we high twice want gap", c); end
            prev_we = vram_we;
            for (int i = 0; i < NUM_REQ; i++) if (ack[i]) grants[i]++;
        end
        req = '0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_busy: got %b want 0", busy); end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_cmp++; if (grants[i] != 2) begin n_err++; $display("FAIL rr_fair req%0d: got %0d grants want 2", i, grants[i]); end
        end
    endtask

    task automatic test_oob();
        do_reset();
        set_slot(0, 15'd19200, 3'd7);
        req = 3'b001;
        step();
        req = 3'b000;
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL oob_ack: got %b want 001", ack); end
        n_cmp++; if (oob_error !== 1'b1) begin n_err++; $display("FAIL oob_flag: got %b want 1", oob_error); end
        n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL oob_we: got %b want 0", vram_we); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL oob_busy: got %b want 1", busy); end
        step();
        n_cmp++; if (oob_error !== 1'b0) begin n_err++; $display("FAIL oob_gap_flag: got %b want 0", oob_error); end
        set_slot(0, 15'd19199, 3'd6);
        req = 3'b001;
        step();
        req = 3'b000;
        n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL edge_we: got %b want 1", vram_we); end
        n_cmp++; if (vram_addr !== 15'd19199) begin n_err++; $display("FAIL edge_addr: got %0d want 19199", vram_addr); end
        n_cmp++; if (vram_data !== 3'd6) begin n_err++; $display("FAIL edge_data: got %0d want 6", vram_data); end
        n_cmp++; if (oob_error !== 1'b0) begin n_err++; $display("FAIL edge_oob: got %b want 0", oob_error); end
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL edge_ack: got %b want 001", ack); end
        step();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_slot(2, 15'd555, 3'd4);
        req = 3'b100;
        step();
        n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL arst_pre_we: got %b want 1", vram_we); end
        #4;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL arst_we: got %b want 0", vram_we); end
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL arst_ack: got %b want 000", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
        n_cmp++; if (vram_addr !== '0) begin n_err++; $display("FAIL arst_addr: got %0d want 0", vram_addr); end
        @(negedge clk);
        set_slot(0, 15'd11, 3'd1);
        set_slot(1, 15'd22, 3'd2);
        req = 3'b111;
        rst_n = 1'b1;
        step();
        req = 3'b000;
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL arst_prio_ack: got %b want 001", ack); end
        n_cmp++; if (vram_addr !== 15'd11) begin n_err++; $display("FAIL arst_prio_addr: got %0d want 11", vram_addr); end
        step();
        step();
    endtask

    task automatic new_write(input int i);
        logic [ADDR_W-1:0] a;
        if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(PIXELS, (1 << ADDR_W) - 1));
        else a = ADDR_W'($urandom_range(0, PIXELS - 1));
        set_slot(i, a, DATA_W'($urandom_range(0, (1 << DATA_W) - 1)));
    endtask

    task automatic test_random();
        int   m_last;
        bit   m_prev;
        bit   slot;
        int   w;
        logic [NUM_REQ-1:0] s_req;
        logic [ADDR_W-1:0]  s_addr[NUM_REQ];
        logic [DATA_W-1:0]  s_data[NUM_REQ];
        logic [NUM_REQ-1:0] e_ack;
        logic e_we, e_oob, e_busy, prev_we;
        logic [ADDR_W-1:0]  e_addr;
        logic [DATA_W-1:0]  e_data;
        logic [ADDR_W+DATA_W-1:0] got;
        do_reset();
        m_last = NUM_REQ - 1;
        m_prev = 1'b0;
        prev_we = 1'b0;
        e_addr = '0;
        e_data = '0;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            s_req = req;
            for (int i = 0; i < NUM_REQ; i++) begin
                s_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
                s_data[i] = req_data[i*DATA_W +: DATA_W];
            end
            step();
            slot  = !m_prev && (s_req != '0);
            e_ack = '0;
            e_we  = 1'b0;
            e_oob = 1'b0;
            if (slot) begin
                w = -1;
                for (int j = 1; j <= NUM_REQ; j++) begin
                    int k = (m_last + j) % NUM_REQ;
                    if (w < 0 && s_req[k]) w = k;
                end
                e_ack[w] = 1'b1;
                e_oob  = (int'(s_addr[w]) >= PIXELS);
                e_we   = !e_oob;
                e_addr = s_addr[w];
                e_data = s_data[w];
                m_last = w;
                if (e_we) exp_q.push_back({e_addr, e_data});
            end
            e_busy = slot || m_prev;
            m_prev = slot;
            n_cmp++; if (ack !== e_ack) begin n_err++; $display("FAIL rnd_ack c=%0d: got %b want %b", c, ack, e_ack); end
            n_cmp++; if (vram_we !== e_we) begin n_err++; $display("FAIL rnd_we c=%0d: got %b want %b", c, vram_we, e_we); end
            n_cmp++; if (oob_error !== e_oob) begin n_err++; $display("FAIL rnd_oob c=%0d: got %b want %b", c, oob_error, e_oob); end
            n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, e_busy); end
            n_cmp++; if (vram_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr c=%0d: got %0d want %0d", c, vram_addr, e_addr); end
            n_cmp++; if (vram_data !== e_data) begin n_err++; $display("FAIL rnd_data c=%0d: got %0d want %0d", c, vram_data, e_data); end
            n_cmp++; if (prev_we && vram_we) begin n_err++; $display("FAIL rnd_spacing c=%0d: got we high twice want gap", c); end
            prev_we = vram_we;
            if (vram_we === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_sb_extra c=%0d: got write %0d want none", c, vram_addr);
                end else begin
                    got = exp_q.pop_front();
                    if ({vram_addr, vram_data} !== got) begin
                        n_err++; $display("FAIL rnd_sb c=%0d: got %h want %h", c, {vram_addr, vram_data}, got);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (c >= 590) req[i] = 1'b0;
                else if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 1) == 1) new_write(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    new_write(i);
                    req[i] = 1'b1;
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_sb_left: got %0d pending want 0", exp_q.size()); end
    endtask

`ifdef VRAM_CLEAR_ENGINE_EN
    task automatic test_clear();
        int busy_cycles;
        int next_addr;
        bit done;
        logic prev_we;
        do_reset();
        set_slot(2, 15'd50, 3'd1);
        req = 3'b100;
        clear_color = 3'd3;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        n_cmp++; if (clear_busy !== 1'b1) begin n_err++; $display("FAIL clr_busy_start: got %b want 1", clear_busy); end
        n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL clr_first_we: got %b want 1", vram_we); end
        n_cmp++; if (vram_addr !== '0) begin n_err++; $display("FAIL clr_first_addr: got %0d want 0", vram_addr); end
        n_cmp++; if (vram_data !== 3'd3) begin n_err++; $display("FAIL clr_first_data: got %0d want 3", vram_data); end
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL clr_first_ack: got %b want 000", ack); end
        busy_cycles = 1;
        next_addr = 1;
        done = 1'b0;
        prev_we = vram_we;
        for (int c = 0; c < 40000 && !done; c++) begin
            if (c == 1000) begin
                clear_start = 1'b1;
                clear_color = 3'd5;
            end else begin
                clear_start = 1'b0;
            end
            step();
            if (clear_busy === 1'b1) begin
                busy_cycles++;
                n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL clr_ack c=%0d: got %b want 000", c, ack); end
                n_cmp++; if (prev_we && vram_we) begin n_err++; $display("FAIL clr_spacing c=%0d: got we high twice want gap", c); end
                if (vram_we === 1'b1) begin
                    n_cmp++; if (int'(vram_addr) != next_addr) begin n_err++; $display("FAIL clr_addr: got %0d want %0d", vram_addr, next_addr); end
                    n_cmp++; if (vram_data !== 3'd3) begin n_err++; $display("FAIL clr_data at %0d: got %0d want 3", next_addr, vram_data); end
                    next_addr++;
                end
                prev_we = vram_we;
            end else begin
                done = 1'b1;
            end
        end
        clear_start = 1'b0;
        n_cmp++; if (!done) begin n_err++; $display("FAIL clr_timeout: got clear_busy stuck want fall within budget"); end
        n_cmp++; if (busy_cycles != 2 * PIXELS) begin n_err++; $display("FAIL clr_duration: got %0d want %0d", busy_cycles, 2 * PIXELS); end
        n_cmp++; if (next_addr != PIXELS) begin n_err++; $display("FAIL clr_count: got %0d want %0d", next_addr, PIXELS); end
        req = 3'b000;
        n_cmp++; if (ack !== 3'b100) begin n_err++; $display("FAIL clr_after_ack: got %b want 100", ack); end
        n_cmp++; if (vram_addr !== 15'd50) begin n_err++; $display("FAIL clr_after_addr: got %0d want 50", vram_addr); end
        n_cmp++; if (vram_data !== 3'd1) begin n_err++; $display("FAIL clr_after_data: got %0d want 1", vram_data); end
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_end_busy: got %b want 0", busy); end
    endtask
`else
    task automatic test_clear_ignored();
        do_reset();
        set_slot(1, 15'd77, 3'd2);
        req = 3'b010;
        clear_color = 3'd3;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        req = 3'b000;
        n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL noclr_busy: got %b want 0", clear_busy); end
        n_cmp++; if (ack !== 3'b010) begin n_err++; $display("FAIL noclr_ack: got %b want 010", ack); end
        n_cmp++; if (vram_addr !== 15'd77) begin n_err++; $display("FAIL noclr_addr: got %0d want 77", vram_addr); end
        n_cmp++; if (vram_data !== 3'd2) begin n_err++; $display("FAIL noclr_data: got %0d want 2", vram_data); end
        step();
        step();
        n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL noclr_busy_later: got %b want 0", clear_busy); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noclr_idle: got %b want 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_oob();
        test_async_reset();
        test_random();
`ifdef VRAM_CLEAR_ENGINE_EN
        test_clear();
`else
        test_clear_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
